seq_restoring_divider: RTL and testbench

//  Multi-cycle unsigned restoring divider: quotient = dividend / divisor, remainder = dividend % divisor.

---
 rtl/seq_restoring_divider_if.sv | 24 ++
 rtl/seq_restoring_divider.sv | 182 ++++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/seq_restoring_divider_if.sv
// Handshake and result bundle for the sequential restoring divider.
// The requester drives start and the operands. The divider returns status and results.
interface seq_restoring_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider that produces one quotient bit per clock.
// A single ripple subtractor is shared across all iterations. Results hold until the next DONE.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_restoring_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] res_rem_q, res_rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] acc_next_s;
    logic [WIDTH-1:0] rem_next_s;
    logic             last_s;
    logic             accept_s;
    logic             zero_div_s;

    // Chain of full-subtractor cells. The top bit of the difference is the sign of the trial.
    function automatic logic [WIDTH:0] ripple_sub(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
        logic [WIDTH:0] diff;
        logic           borrow;
        borrow = 1'b0;
        for (int i = 0; i <= WIDTH; i++) begin
            diff[i] = a[i] ^ b[i] ^ borrow;
            borrow  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow);
        end
        return diff;
    endfunction

    assign accept_s   = (state_q == S_IDLE) && bus.start;
    assign zero_div_s = (bus.divisor == {WIDTH{1'b0}});
    assign last_s     = (cnt_q == CW'(WIDTH - 1));

    // The partial remainder stays below the divisor, so WIDTH bits hold it; only the shifted value needs WIDTH+1.
    assign shifted_s  = {rem_q, acc_q[WIDTH-1]};
    assign trial_s    = ripple_sub(shifted_s, {1'b0, dvs_q});
    assign acc_next_s = {acc_q[WIDTH-2:0], ~trial_s[WIDTH]};
    assign rem_next_s = trial_s[WIDTH] ? shifted_s[WIDTH-1:0] : trial_s[WIDTH-1:0];

    // State register and the registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = zero_div_s ? S_DONE : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status flags are decoded from the next state so that they can be registered with it.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
            S_RUN: begin
                busy_d = 1'b1;
                done_d = 1'b0;
            end
            S_DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // Iteration datapath and result capture.
    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        acc_d     = acc_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        res_rem_d = res_rem_q;
        dbz_d     = dbz_q;
        if (accept_s) begin
            if (zero_div_s) begin
                quo_d     = {WIDTH{1'b1}};
                res_rem_d = bus.dividend;
                dbz_d     = 1'b1;
            end else begin
                cnt_d = {CW{1'b0}};
                rem_d = {WIDTH{1'b0}};
                acc_d = bus.dividend;
                dvs_d = bus.divisor;
            end
        end else if (state_q == S_RUN) begin
            cnt_d = cnt_q + CW'(1);
            rem_d = rem_next_s;
            acc_d = acc_next_s;
            if (last_s) begin
                quo_d     = acc_next_s;
                res_rem_d = rem_next_s;
                dbz_d     = 1'b0;
            end else begin
                quo_d     = quo_q;
                res_rem_d = res_rem_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers. On reset, any operation in progress is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= {CW{1'b0}};
            rem_q     <= {WIDTH{1'b0}};
            acc_q     <= {WIDTH{1'b0}};
            dvs_q     <= {WIDTH{1'b0}};
            quo_q     <= {WIDTH{1'b0}};
            res_rem_q <= {WIDTH{1'b0}};
            dbz_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            acc_q     <= acc_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            res_rem_q <= res_rem_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = res_rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and random checks of seq_restoring_divider at WIDTH=8.
module tb_seq_restoring_divider;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    seq_restoring_divider_if #(.WIDTH(W)) bus ();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Waits for IDLE, issues one request, and then scrambles the operands after the accept edge.
    // lat is the number of edges from accept until done is seen, or -1 on timeout.
    task automatic run_div(input logic [W-1:0] n, input logic [W-1:0] d, output int lat);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.dividend = n; bus.divisor = d;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.dividend = ~n; bus.divisor = d + 8'd1;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus.done !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd2;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
        tests++; if (bus.quotient !== 8'd0 || bus.remainder !== 8'd0 || bus.div_by_zero !== 1'b0) begin
            fails++; $display("FAIL reset_results got q=%0d r=%0d z=%b want 0 0 0", bus.quotient, bus.remainder, bus.div_by_zero);
        end
        bus.start = 1'b0; rst = 1'b0;
    endtask

    task automatic test_basic();
        int c;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        tests++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin fails++; $display("FAIL basic_busy_after_accept got busy=%b done=%b want 1 0", bus.busy, bus.done); end
        c = 0;
        while (bus.done !== 1'b1 && c < 40) begin @(posedge clk); #1; c++; end
        tests++; if (c !== 8) begin fails++; $display("FAIL basic_latency got %0d want 8", c); end
        tests++; if (bus.quotient !== 8'd14 || bus.remainder !== 8'd2 || bus.div_by_zero !== 1'b0) begin
            fails++; $display("FAIL basic_100_7 got q=%0d r=%0d z=%b want 14 2 0", bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(posedge clk); #1;
        tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL basic_done_one_cycle got done=%b busy=%b want 0 0", bus.done, bus.busy); end
    endtask

    task automatic test_edges();
        logic [W-1:0] nv [3] = '{8'd255, 8'd5, 8'd200};
        logic [W-1:0] dv [3] = '{8'd1, 8'd9, 8'd200};
        logic [W-1:0] qv [3] = '{8'd255, 8'd0, 8'd1};
        logic [W-1:0] rv [3] = '{8'd0, 8'd5, 8'd0};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_div(nv[i], dv[i], lat);
            tests++; if (lat !== 8 || bus.quotient !== qv[i] || bus.remainder !== rv[i]) begin
                fails++; $display("FAIL edge_%0d_%0d got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=8", nv[i], dv[i], bus.quotient, bus.remainder, lat, qv[i], rv[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        run_div(8'd13, 8'd0, lat);
        tests++; if (lat !== 0) begin fails++; $display("FAIL dbz_latency got %0d want 0 (done right after accept)", lat); end
        tests++; if (bus.quotient !== 8'hFF || bus.remainder !== 8'd13 || bus.div_by_zero !== 1'b1) begin
            fails++; $display("FAIL dbz_13_0 got q=%0h r=%0d z=%b want ff 13 1", bus.quotient, bus.remainder, bus.div_by_zero);
        end
        // The results must hold through the RUN phase of the next operation.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.dividend = 8'd13; bus.divisor = 8'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.quotient !== 8'hFF || bus.remainder !== 8'd13 || bus.div_by_zero !== 1'b1) begin
            fails++; $display("FAIL dbz_hold_in_run got q=%0h r=%0d z=%b want ff 13 1", bus.quotient, bus.remainder, bus.div_by_zero);
        end
        lat = 3;
        while (bus.done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        tests++; if (lat !== 8 || bus.quotient !== 8'd4 || bus.remainder !== 8'd1 || bus.div_by_zero !== 1'b0) begin
            fails++; $display("FAIL dbz_then_13_3 got q=%0d r=%0d z=%b lat=%0d want 4 1 0 lat=8", bus.quotient, bus.remainder, bus.div_by_zero, lat);
        end
    endtask

    task automatic test_ignored_start();
        int early;
        int lat;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        early = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c < 8 && bus.done === 1'b1) early++;
            if (c == 3) begin bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5; end
            if (c == 4) bus.start = 1'b0;
        end
        tests++; if (early !== 0 || bus.done !== 1'b1) begin fails++; $display("FAIL ign_done_timing got early=%0d done=%b want 0 1", early, bus.done); end
        tests++; if (bus.quotient !== 8'd14 || bus.remainder !== 8'd2) begin fails++; $display("FAIL ign_result got q=%0d r=%0d want 14 2", bus.quotient, bus.remainder); end
        bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 8'd14 || bus.remainder !== 8'd2) begin
            fails++; $display("FAIL ign_not_queued got busy=%b done=%b q=%0d r=%0d want 0 0 14 2", bus.busy, bus.done, bus.quotient, bus.remainder);
        end
        run_div(8'd50, 8'd5, lat);
        tests++; if (lat !== 8 || bus.quotient !== 8'd10 || bus.remainder !== 8'd0) begin
            fails++; $display("FAIL ign_then_50_5 got q=%0d r=%0d lat=%0d want 10 0 lat=8", bus.quotient, bus.remainder, lat);
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        int lat;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 8'd0 || bus.remainder !== 8'd0) begin
            fails++; $display("FAIL abort_state got busy=%b done=%b q=%0d r=%0d want 0 0 0 0", bus.busy, bus.done, bus.quotient, bus.remainder);
        end
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) pulses++;
        end
        tests++; if (pulses !== 0) begin fails++; $display("FAIL abort_no_done got %0d pulses want 0", pulses); end
        run_div(8'd77, 8'd8, lat);
        tests++; if (lat !== 8 || bus.quotient !== 8'd9 || bus.remainder !== 8'd5) begin
            fails++; $display("FAIL abort_then_77_8 got q=%0d r=%0d lat=%0d want 9 5 lat=8", bus.quotient, bus.remainder, lat);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] n;
        logic [W-1:0] d;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            n  = W'($urandom_range(0, 255));
            d  = W'($urandom_range(1, 255));
            eq = n / d;
            er = n % d;
            run_div(n, d, lat);
            tests++;
            if (lat !== 8 || bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== 1'b0 ||
                (32'(bus.quotient) * 32'(d) + 32'(bus.remainder)) !== 32'(n)) begin
                fails++;
                $display("FAIL rand_%0d_%0d got q=%0d r=%0d z=%b lat=%0d want q=%0d r=%0d z=0 lat=8", n, d, bus.quotient, bus.remainder, bus.div_by_zero, lat, eq, er);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.dividend = 8'd0; bus.divisor = 8'd0;
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_ignored_start();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
